giaima_scan_sequencer: RTL and testbench



---
 rtl/giaima_scan_sequencer_if.sv | 32 +++
 rtl/giaima_scan_sequencer.sv | 134 +++++++++++++
 tb/tb_giaima_scan_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/giaima_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : giaima_scan_sequencer_if
// Description : Control/status bundle between a scan-sequencer client and the
//               giaima_scan_sequencer block.
//               Client -> sequencer : en, start, mode, dir, last
//               Sequencer -> client : sel, sel_en, tick, wrap, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface giaima_scan_sequencer_if;
    logic       en;
    logic       start;
    logic       mode;
    logic       dir;
    logic [2:0] last;
    logic [2:0] sel;
    logic       sel_en;
    logic       tick;
    logic       wrap;
    logic       busy;

    modport master (
        output en, start, mode, dir, last,
        input  sel, sel_en, tick, wrap, busy
    );

    modport slave (
        input  en, start, mode, dir, last,
        output sel, sel_en, tick, wrap, busy
    );
endinterface
`default_nettype wire

// File: rtl/giaima_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : giaima_scan_sequencer
// Description : Steps a 3-bit channel select through 0..last (up or down) at
//               one step per DIV enabled clocks, for driving a 3-to-8 decoder.
//               Continuous or single-sweep operation; all outputs registered.
// Ports       : clk       - system clock, rising edge
//               rst       - asynchronous, active-high reset
//               bus.en    - count enable (0 pauses)
//               bus.start - single-cycle request to begin scanning
//               bus.mode  - 0 continuous, 1 single sweep
//               bus.dir   - 0 up, 1 down
//               bus.last  - highest active channel index
//               bus.sel   - channel select
//               bus.sel_en- decoder enable
//               bus.tick  - pulse on every select step
//               bus.wrap  - pulse when a sweep completes
//               bus.busy  - high while running
// Revision    : 1.0 - initial release
// ============================================================================
module giaima_scan_sequencer #(
    parameter int DIV   = 4,
    parameter int DIV_W = 16
) (
    input  wire                        clk,
    input  wire                        rst,
    giaima_scan_sequencer_if.slave     bus
);

    localparam logic [DIV_W-1:0] PRESC_TERM = DIV_W'(DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state,      state_next;
    logic [DIV_W-1:0] presc,      presc_next;
    logic [2:0]       sel_reg,    sel_next;
    logic             sel_en_reg, sel_en_next;
    logic             tick_reg,   tick_next;
    logic             wrap_reg,   wrap_next;
    logic             busy_reg,   busy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            presc      <= '0;
            sel_reg    <= 3'd0;
            sel_en_reg <= 1'b0;
            tick_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            sel_reg    <= sel_next;
            sel_en_reg <= sel_en_next;
            tick_reg   <= tick_next;
            wrap_reg   <= wrap_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state;
        presc_next  = presc;
        sel_next    = sel_reg;
        sel_en_next = 1'b0;
        tick_next   = 1'b0;
        wrap_next   = 1'b0;
        busy_next   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start && bus.en) begin
                    state_next  = ST_RUN;
                    presc_next  = '0;
                    sel_next    = bus.dir ? bus.last : 3'd0;
                    sel_en_next = 1'b1;
                    busy_next   = 1'b1;
                end
            end

            ST_RUN: begin
                busy_next   = 1'b1;
                // Decoder is blanked while paused; prescaler and select freeze.
                sel_en_next = bus.en;
                if (bus.en) begin
                    if (presc == PRESC_TERM) begin
                        presc_next = '0;
                        tick_next  = 1'b1;
                        // ">=" so a select left above a lowered limit wraps.
                        if (!bus.dir) begin
                            if (sel_reg < bus.last) begin
                                sel_next = sel_reg + 3'd1;
                            end else begin
                                sel_next  = 3'd0;
                                wrap_next = 1'b1;
                            end
                        end else begin
                            if (sel_reg != 3'd0) begin
                                sel_next = sel_reg - 3'd1;
                            end else begin
                                sel_next  = bus.last;
                                wrap_next = 1'b1;
                            end
                        end
                        // Single sweep ends on the wrap step itself.
                        if (wrap_next && bus.mode) begin
                            state_next  = ST_IDLE;
                            busy_next   = 1'b0;
                            sel_en_next = 1'b0;
                        end
                    end else begin
                        presc_next = presc + DIV_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.sel    = sel_reg;
    assign bus.sel_en = sel_en_reg;
    assign bus.tick   = tick_reg;
    assign bus.wrap   = wrap_reg;
    assign bus.busy   = busy_reg;

endmodule
`default_nettype wire

// File: tb/tb_giaima_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_giaima_scan_sequencer
// Description : Directed bench for giaima_scan_sequencer. Instance a uses
//               DIV=4, instance b uses DIV=1. Inputs change 1 ns after a
//               rising edge; outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_giaima_scan_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    giaima_scan_sequencer_if bus_a ();
    giaima_scan_sequencer_if bus_b ();

    giaima_scan_sequencer #(.DIV(4), .DIV_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    giaima_scan_sequencer #(.DIV(1), .DIV_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.dir = 1'b0; bus_a.last = 3'd7;
        bus_b.en = 1'b0; bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.dir = 1'b0; bus_b.last = 3'd0;

        // Reset state
        cyc(2);
        chk("rst_sel",    {29'd0, bus_a.sel}, 32'd0);
        chk("rst_sel_en", {31'd0, bus_a.sel_en}, 32'd0);
        chk("rst_busy",   {31'd0, bus_a.busy}, 32'd0);
        chk("rst_tick",   {31'd0, bus_a.tick}, 32'd0);
        chk("rst_wrap",   {31'd0, bus_a.wrap}, 32'd0);
        rst = 1'b0;

        // Continuous up scan, LAST=7
        bus_a.en = 1'b1; bus_a.start = 1'b1;
        cyc(1);
        bus_a.start = 1'b0;
        chk("up_start_sel",    {29'd0, bus_a.sel}, 32'd0);
        chk("up_start_sel_en", {31'd0, bus_a.sel_en}, 32'd1);
        chk("up_start_busy",   {31'd0, bus_a.busy}, 32'd1);
        chk("up_start_tick",   {31'd0, bus_a.tick}, 32'd0);
        for (int s = 1; s <= 8; s++) begin
            cyc(3);
            chk("up_hold_sel",  {29'd0, bus_a.sel}, 32'((s - 1) % 8));
            chk("up_hold_tick", {31'd0, bus_a.tick}, 32'd0);
            chk("up_hold_wrap", {31'd0, bus_a.wrap}, 32'd0);
            cyc(1);
            chk("up_step_sel",  {29'd0, bus_a.sel}, 32'(s % 8));
            chk("up_step_tick", {31'd0, bus_a.tick}, 32'd1);
            chk("up_step_wrap", {31'd0, bus_a.wrap}, (s == 8) ? 32'd1 : 32'd0);
        end

        // Pause at SEL=3 after two enabled cycles
        cyc(12);
        chk("pre_pause_sel", {29'd0, bus_a.sel}, 32'd3);
        cyc(2);
        bus_a.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("pause_sel",    {29'd0, bus_a.sel}, 32'd3);
            chk("pause_sel_en", {31'd0, bus_a.sel_en}, 32'd0);
            chk("pause_tick",   {31'd0, bus_a.tick}, 32'd0);
            chk("pause_busy",   {31'd0, bus_a.busy}, 32'd1);
        end
        bus_a.en = 1'b1;
        cyc(1);
        chk("resume1_sel",    {29'd0, bus_a.sel}, 32'd3);
        chk("resume1_sel_en", {31'd0, bus_a.sel_en}, 32'd1);
        chk("resume1_tick",   {31'd0, bus_a.tick}, 32'd0);
        cyc(1);
        chk("resume2_sel",  {29'd0, bus_a.sel}, 32'd4);
        chk("resume2_tick", {31'd0, bus_a.tick}, 32'd1);

        // LAST lowered to 2 while at SEL=6
        cyc(8);
        chk("at6_sel", {29'd0, bus_a.sel}, 32'd6);
        bus_a.last = 3'd2;
        cyc(4);
        chk("last2_wrap_sel", {29'd0, bus_a.sel}, 32'd0);
        chk("last2_wrap",     {31'd0, bus_a.wrap}, 32'd1);
        cyc(4);
        chk("last2_sel1", {29'd0, bus_a.sel}, 32'd1);
        chk("last2_nowrap", {31'd0, bus_a.wrap}, 32'd0);
        cyc(4);
        chk("last2_sel2", {29'd0, bus_a.sel}, 32'd2);
        cyc(4);
        chk("last2_sel0", {29'd0, bus_a.sel}, 32'd0);
        chk("last2_wrap2", {31'd0, bus_a.wrap}, 32'd1);

        // Asynchronous reset mid-cycle at SEL=4
        bus_a.last = 3'd7;
        cyc(16);
        chk("pre_rst_sel",  {29'd0, bus_a.sel}, 32'd4);
        chk("pre_rst_tick", {31'd0, bus_a.tick}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sel",    {29'd0, bus_a.sel}, 32'd0);
        chk("arst_sel_en", {31'd0, bus_a.sel_en}, 32'd0);
        chk("arst_busy",   {31'd0, bus_a.busy}, 32'd0);
        chk("arst_tick",   {31'd0, bus_a.tick}, 32'd0);
        chk("arst_wrap",   {31'd0, bus_a.wrap}, 32'd0);
        cyc(1);
        rst = 1'b0;
        bus_a.en = 1'b0; bus_a.start = 1'b1;
        cyc(1);
        bus_a.start = 1'b0;
        chk("start_en0_busy",   {31'd0, bus_a.busy}, 32'd0);
        chk("start_en0_sel_en", {31'd0, bus_a.sel_en}, 32'd0);
        bus_a.en = 1'b1; bus_a.start = 1'b1;
        cyc(1);
        bus_a.start = 1'b0;
        chk("restart_sel",    {29'd0, bus_a.sel}, 32'd0);
        chk("restart_sel_en", {31'd0, bus_a.sel_en}, 32'd1);
        chk("restart_busy",   {31'd0, bus_a.busy}, 32'd1);
        // START while running must not restart the prescaler
        cyc(1);
        bus_a.start = 1'b1;
        cyc(1);
        bus_a.start = 1'b0;
        cyc(1);
        chk("run_start_sel",  {29'd0, bus_a.sel}, 32'd0);
        chk("run_start_tick", {31'd0, bus_a.tick}, 32'd0);
        cyc(1);
        chk("run_start_step_sel",  {29'd0, bus_a.sel}, 32'd1);
        chk("run_start_step_tick", {31'd0, bus_a.tick}, 32'd1);

        // Single sweep, down, LAST=5
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus_a.mode = 1'b1; bus_a.dir = 1'b1; bus_a.last = 3'd5; bus_a.en = 1'b1; bus_a.start = 1'b1;
        cyc(1);
        bus_a.start = 1'b0;
        chk("dn_start_sel",  {29'd0, bus_a.sel}, 32'd5);
        chk("dn_start_busy", {31'd0, bus_a.busy}, 32'd1);
        for (int s = 4; s >= 0; s--) begin
            cyc(4);
            chk("dn_sel",  {29'd0, bus_a.sel}, 32'(s));
            chk("dn_tick", {31'd0, bus_a.tick}, 32'd1);
            chk("dn_wrap", {31'd0, bus_a.wrap}, 32'd0);
            chk("dn_busy", {31'd0, bus_a.busy}, 32'd1);
        end
        cyc(4);
        chk("dn_end_sel",    {29'd0, bus_a.sel}, 32'd5);
        chk("dn_end_wrap",   {31'd0, bus_a.wrap}, 32'd1);
        chk("dn_end_tick",   {31'd0, bus_a.tick}, 32'd1);
        chk("dn_end_busy",   {31'd0, bus_a.busy}, 32'd0);
        chk("dn_end_sel_en", {31'd0, bus_a.sel_en}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("idle_tick", {31'd0, bus_a.tick}, 32'd0);
            chk("idle_busy", {31'd0, bus_a.busy}, 32'd0);
            chk("idle_sel",  {29'd0, bus_a.sel}, 32'd5);
        end

        // DIV=1, LAST=0, continuous
        bus_b.en = 1'b1; bus_b.start = 1'b1;
        cyc(1);
        bus_b.start = 1'b0;
        chk("d1_start_sel",  {29'd0, bus_b.sel}, 32'd0);
        chk("d1_start_busy", {31'd0, bus_b.busy}, 32'd1);
        chk("d1_start_tick", {31'd0, bus_b.tick}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("d1_sel",  {29'd0, bus_b.sel}, 32'd0);
            chk("d1_tick", {31'd0, bus_b.tick}, 32'd1);
            chk("d1_wrap", {31'd0, bus_b.wrap}, 32'd1);
        end
        bus_b.en = 1'b0;
        cyc(1);
        chk("d1_pause_tick",   {31'd0, bus_b.tick}, 32'd0);
        chk("d1_pause_wrap",   {31'd0, bus_b.wrap}, 32'd0);
        chk("d1_pause_sel_en", {31'd0, bus_b.sel_en}, 32'd0);
        chk("d1_pause_busy",   {31'd0, bus_b.busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
